rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter for the 32×32 register file. Shares the single RF write port between the in-order pipeline writeback stage and a long-latency multi-cycle unit (mult/div result path). Multi-cycle results are buffered in a small FIFO and drained into free writeback slots, with a starvation guard. Pending-write flags let decode detect RAW/WAW hazards against buffered results.

## Interface
Parameters:
- `DEPTH`, 2: multi-cycle result FIFO entries; power of 2, ≥2.
- `MAX_WAIT`, 4: cycles a non-empty FIFO may go without a pop before the pipeline is stalled; 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `wb_we`  in  1  pipeline writeback request.
- `wb_addr`  in  5  pipeline destination register.
- `wb_data`  in  32  pipeline write data.
- `mc_valid`  in  1  multi-cycle result valid.
- `mc_ready`  out  1  FIFO can accept a result.
- `mc_addr`  in  5  multi-cycle destination register.
- `mc_data`  in  32  multi-cycle result.
- `rf_we`  out  1  to RF `RFWr`.
- `rf_w`  out  5  to RF `W`.
- `rf_din`  out  32  to RF `din`.
- `stall_pipe`  out  1  pipeline must hold its WB stage and present no write.
- `rd_a`, `rd_b`, `rd_w`  in  5 each  decode source A, source B, destination.
- `pend_a`, `pend_b`, `pend_w`  out  1 each  a buffered FIFO write targets that register.

## Operation
- Write to `$0` is a non-request: `wb_we` with `wb_addr==0` is treated as idle; an `mc` result with `mc_addr==0` is accepted by the handshake and discarded (not pushed).
- Push: `mc_valid && mc_ready` with a non-zero address enqueues {addr, data}. `mc_ready = !full`; no pass-through from `mc_*` to RF.
- Grant per cycle, combinational:
  - `stall_pipe==1`: FIFO head wins; `wb_*` ignored.
  - else effective `wb_we`: pipeline wins; `rf_*` = `wb_*`.
  - else FIFO non-empty: head wins, pop.
  - else `rf_we=0`.
- Push and pop in the same cycle are legal at any occupancy except push when full (blocked by `mc_ready`).
- Starvation counter `wait_cnt`: reset to 0 on any pop or when FIFO empty; else +1 per cycle, saturating. `stall_pipe` is registered: set when next `wait_cnt` reaches `MAX_WAIT`; cleared the cycle after the pop it forces.
- `pend_x = (rd_x != 0) && any valid entry with addr == rd_x`. Computed from FIFO contents only, before this cycle's push/pop. Decode stalls on `pend_*`; this guarantees pipeline writes never overtake an older buffered write to the same register.

## Timing
- Pipeline path: zero latency; `rf_*` is combinational from `wb_*` in the same cycle.
- `mc` path: minimum 1 cycle; push at edge N, written to RF at edge N+1 if that slot is free.
- Worst-case head wait: `MAX_WAIT`+1 cycles from becoming head.
- Reset (asynchronous, any time, including mid-drain):
  - FIFO empty, pointers 0.
  - `wait_cnt=0`, `stall_pipe=0`.
  - `rf_we` forced 0 while `rst_n` is low.
  - `mc_ready=1`.
  - `pend_*=0`.
  - Buffered results are lost.
- Full FIFO with pipeline writing every cycle: `mc_ready=0` until the guard forces a drain slot.

## Configuration
- `RF_ARB_STARVE_EN` defined: starvation guard as above.
- Undefined:
  - `wait_cnt` is removed and `stall_pipe` is tied 0.
  - FIFO drains only in idle pipeline slots; `MAX_WAIT` is unused.

## Structure
- Shared package holds:
  - `RF_AW=5` and `RF_DW=32`.
  - `REG_ZERO=5'd0`.
  - Packed write-request type {addr, data}, used by the arbiter and the FIFO.
- One sub-module, `rf_arb_fifo`:
  - Parameterised-depth FIFO of write requests.
  - Exposes `full`/`empty`, the head entry, and a per-entry valid+addr vector for the pend compare.

## Test plan
- Reset, then `mc` push {r5, 0x11} with idle pipe → `rf_we=1`, `rf_w=5`, `rf_din=0x11` the next cycle; `pend_a` high for `rd_a=5` only during the buffered cycle.
- Pipeline writes r3 every cycle while `mc` pushes r7 → pipeline writes proceed; r7 held until the guard; with `MAX_WAIT=4`, `stall_pipe` rises after 4 cycles; r7 is written in the stall cycle; `stall_pipe` drops the next cycle.
- Fill FIFO (`DEPTH=2`) under a continuous pipeline write → `mc_ready=0`; third result held by the producer and accepted after the first forced pop.
- `wb_we=1`, `wb_addr=0`, FIFO holds r9 → FIFO head written that cycle; `mc` result to r0 accepted and never written.
- Assert `rst_n` low mid-drain with 2 entries buffered → `rf_we=0` immediately; after release: empty, `mc_ready=1`, `stall_pipe=0`, no spurious writes.
- Build without `RF_ARB_STARVE_EN`, continuous pipeline writes for 20 cycles → `stall_pipe` stays 0; FIFO head is drained only in the first idle slot.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   RF_AW / RF_DW : register-file address and data widths
//   REG_ZERO      : the hard-wired zero register
//   wr_req_t      : packed {addr, data} write request, used by the arbiter and its FIFO
//   is_real_write : a write to $0 is never a real write
package rf_wb_arbiter_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wr_req_t;

  function automatic logic is_real_write(input logic [RF_AW-1:0] addr);
    return addr != REG_ZERO;
  endfunction
endpackage

// File: rtl/rf_arb_fifo.sv
// FIFO of buffered multi-cycle write requests.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, push_req : enqueue push_req (caller guarantees !full)
//   pop            : dequeue the head (caller guarantees !empty)
//   full, empty    : occupancy flags
//   head           : oldest entry
//   ent_valid      : per-slot valid bits
//   ent_addr       : per-slot destination addresses, slot i at [i*RF_AW +: RF_AW]
module rf_arb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wr_req_t                push_req,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output wr_req_t                head,
  output logic [DEPTH-1:0]       ent_valid,
  output logic [DEPTH*RF_AW-1:0] ent_addr
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_req_t          mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Occupancy is tracked as per-slot valid bits so the pend compare can use
  // them directly. A push never lands on the popped slot: push needs !full
  // and pop needs !empty, so the two indices always differ.
  always_comb begin
    valid_nxt = valid;
    if (pop)  valid_nxt[rd_ptr] = 1'b0;
    if (push) valid_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      valid <= valid_nxt;
      if (push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    ent_addr = '0;
    for (int i = 0; i < DEPTH; i++) ent_addr[i*RF_AW +: RF_AW] = mem[i].addr;
  end

  assign ent_valid = valid;
  assign head      = mem[rd_ptr];
  assign full      = &valid;
  assign empty     = ~|valid;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file. The pipeline writeback
// stage and a buffered multi-cycle result path share one RF write port.
// Optional feature macro: RF_ARB_STARVE_EN (starvation guard that stalls the
// pipeline when the FIFO head has waited MAX_WAIT cycles).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wb_we, wb_addr, wb_data    : pipeline writeback request
//   mc_valid, mc_ready,
//   mc_addr, mc_data           : multi-cycle result handshake
//   rf_we, rf_w, rf_din        : RF write port
//   stall_pipe                 : pipeline must hold WB and present no write
//   rd_a, rd_b, rd_w           : decode register numbers
//   pend_a, pend_b, pend_w     : a buffered write targets that register
// Handshake: a result transfers on a rising edge where mc_valid && mc_ready;
// mc_valid/addr/data must hold until then. A transfer to $0 is consumed but
// not buffered.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_we,
  input  logic [RF_AW-1:0] wb_addr,
  input  logic [RF_DW-1:0] wb_data,
  input  logic             mc_valid,
  output logic             mc_ready,
  input  logic [RF_AW-1:0] mc_addr,
  input  logic [RF_DW-1:0] mc_data,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_w,
  output logic [RF_DW-1:0] rf_din,
  output logic             stall_pipe,
  input  logic [RF_AW-1:0] rd_a,
  input  logic [RF_AW-1:0] rd_b,
  input  logic [RF_AW-1:0] rd_w,
  output logic             pend_a,
  output logic             pend_b,
  output logic             pend_w
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1 || MAX_WAIT > 15)
  begin : g_bad_param
    $error("rf_wb_arbiter: DEPTH must be a power of 2 >= 2, MAX_WAIT 1..15");
  end

  logic                   fifo_full;
  logic                   fifo_empty;
  wr_req_t                fifo_head;
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH*RF_AW-1:0] ent_addr;
  logic                   push;
  logic                   pop;
  logic                   wb_eff;

  assign mc_ready = !fifo_full;
  assign push     = mc_valid && mc_ready && is_real_write(mc_addr);
  assign wb_eff   = wb_we && is_real_write(wb_addr);

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req ('{addr: mc_addr, data: mc_data}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .ent_valid(ent_valid),
    .ent_addr (ent_addr)
  );

  // Grant: a forced drain beats the pipeline, the pipeline beats idle drain.
  always_comb begin
    rf_we  = 1'b0;
    rf_w   = REG_ZERO;
    rf_din = '0;
    pop    = 1'b0;
    if (!rst_n) begin
      pop = 1'b0;
    end else if (stall_pipe) begin
      if (!fifo_empty) begin
        pop    = 1'b1;
        rf_we  = 1'b1;
        rf_w   = fifo_head.addr;
        rf_din = fifo_head.data;
      end
    end else if (wb_eff) begin
      rf_we  = 1'b1;
      rf_w   = wb_addr;
      rf_din = wb_data;
    end else if (!fifo_empty) begin
      pop    = 1'b1;
      rf_we  = 1'b1;
      rf_w   = fifo_head.addr;
      rf_din = fifo_head.data;
    end
  end

`ifdef RF_ARB_STARVE_EN
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic       stall_q;

  // Counts cycles the current head has gone without being popped.
  always_comb begin
    wait_nxt = wait_cnt;
    if (pop || fifo_empty)   wait_nxt = '0;
    else if (wait_cnt != 4'hF) wait_nxt = wait_cnt + 4'd1;
  end

  // The stall stays up until the pop it forces, then drops the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      stall_q  <= pop ? 1'b0 : (stall_q || (wait_nxt >= WAIT_LIM));
    end
  end

  assign stall_pipe = stall_q;
`else
  assign stall_pipe = 1'b0;
`endif

  // Hazard flags look at buffered contents only, ignoring this cycle's push/pop.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    pend_w = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (is_real_write(rd_a) && ent_addr[i*RF_AW +: RF_AW] == rd_a) pend_a = 1'b1;
        if (is_real_write(rd_b) && ent_addr[i*RF_AW +: RF_AW] == rd_b) pend_b = 1'b1;
        if (is_real_write(rd_w) && ent_addr[i*RF_AW +: RF_AW] == rd_w) pend_w = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (DEPTH=2, MAX_WAIT=4). Expectations
// for the starvation-guard build are selected with RF_ARB_STARVE_EN.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        rf_we;
  logic [4:0]  rf_w;
  logic [31:0] rf_din;
  logic        stall_pipe;
  logic [4:0]  rd_a, rd_b, rd_w;
  logic        pend_a, pend_b, pend_w;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
    .rf_we(rf_we), .rf_w(rf_w), .rf_din(rf_din),
    .stall_pipe(stall_pipe),
    .rd_a(rd_a), .rd_b(rd_b), .rd_w(rd_w),
    .pend_a(pend_a), .pend_b(pend_b), .pend_w(pend_w)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] w,
                          input logic [31:0] din);
    check({tag, ".rf_we"}, 64'(rf_we), 64'(we));
    if (we) begin
      check({tag, ".rf_w"}, 64'(rf_w), 64'(w));
      check({tag, ".rf_din"}, 64'(rf_din), 64'(din));
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  task automatic drive_mc(input logic v, input logic [4:0] a, input logic [31:0] d);
    mc_valid = v; mc_addr = a; mc_data = d;
  endtask

  task automatic idle_all();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mc(1'b0, 5'd0, 32'd0);
    rd_a = 5'd0; rd_b = 5'd0; rd_w = 5'd0;
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    // Reset state, with a pipeline write presented that must be suppressed.
    drive_wb(1'b1, 5'd4, 32'h44);
    #3;
    check("rst.rf_we", 64'(rf_we), 64'd0);
    check("rst.mc_ready", 64'(mc_ready), 64'd1);
    check("rst.stall", 64'(stall_pipe), 64'd0);
    check("rst.pend_a", 64'(pend_a), 64'd0);
    idle_all();
    tick();
    rst_n = 1'b1;
    tick();

    // T1: one mc result with idle pipe, written the next cycle.
    drive_mc(1'b1, 5'd5, 32'h11);
    rd_a = 5'd5;
    settle();
    check("t1.push.ready", 64'(mc_ready), 64'd1);
    check("t1.push.rf_we", 64'(rf_we), 64'd0);
    check("t1.push.pend_a", 64'(pend_a), 64'd0);
    tick();
    drive_mc(1'b0, 5'd0, 32'd0);
    settle();
    check_rf("t1.drain", 1'b1, 5'd5, 32'h11);
    check("t1.drain.pend_a", 64'(pend_a), 64'd1);
    tick();
    settle();
    check("t1.after.rf_we", 64'(rf_we), 64'd0);
    check("t1.after.pend_a", 64'(pend_a), 64'd0);
    idle_all();
    tick();

    // T2: pipeline writes r3 every cycle while r7 is buffered.
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_mc(1'b1, 5'd7, 32'h77);
    settle();
    check_rf("t2.push", 1'b1, 5'd3, 32'h33);
    tick();
    drive_mc(1'b0, 5'd0, 32'd0);
    rd_w = 5'd7; rd_b = 5'd3;
`ifdef RF_ARB_STARVE_EN
    for (int c = 0; c < 6; c++) begin
      settle();
      check("t2.stall", 64'(stall_pipe), 64'(c == 4));
      if (c == 4) check_rf("t2.forced", 1'b1, 5'd7, 32'h77);
      else        check_rf("t2.pipe", 1'b1, 5'd3, 32'h33);
      check("t2.pend_w", 64'(pend_w), 64'(c <= 4));
      check("t2.pend_b", 64'(pend_b), 64'd0);
      tick();
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    settle();
    check("t2.empty.rf_we", 64'(rf_we), 64'd0);
`else
    for (int c = 0; c < 20; c++) begin
      settle();
      check("t2.stall", 64'(stall_pipe), 64'd0);
      check_rf("t2.pipe", 1'b1, 5'd3, 32'h33);
      check("t2.pend_w", 64'(pend_w), 64'd1);
      check("t2.pend_b", 64'(pend_b), 64'd0);
      tick();
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    settle();
    check_rf("t2.idle_drain", 1'b1, 5'd7, 32'h77);
    check("t2.idle_drain.pend_w", 64'(pend_w), 64'd1);
    tick();
    settle();
    check("t2.empty.rf_we", 64'(rf_we), 64'd0);
    check("t2.empty.pend_w", 64'(pend_w), 64'd0);
`endif
    idle_all();
    tick();

    // T3: fill the FIFO under continuous pipeline writes.
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_mc(1'b1, 5'd10, 32'hA0);
    settle();
    check("t3.c0.ready", 64'(mc_ready), 64'd1);
    tick();
    drive_mc(1'b1, 5'd11, 32'hB1);
    settle();
    check("t3.c1.ready", 64'(mc_ready), 64'd1);
    tick();
    drive_mc(1'b1, 5'd12, 32'hC2);
`ifdef RF_ARB_STARVE_EN
    for (int c = 2; c < 6; c++) begin
      settle();
      check("t3.full.ready", 64'(mc_ready), 64'd0);
      check("t3.stall", 64'(stall_pipe), 64'(c == 5));
      if (c == 5) check_rf("t3.forced", 1'b1, 5'd10, 32'hA0);
      else        check_rf("t3.pipe", 1'b1, 5'd3, 32'h33);
      tick();
    end
    settle();
    check("t3.accept.ready", 64'(mc_ready), 64'd1);
    check("t3.accept.stall", 64'(stall_pipe), 64'd0);
    check_rf("t3.accept", 1'b1, 5'd3, 32'h33);
    tick();
`else
    for (int c = 2; c < 10; c++) begin
      settle();
      check("t3.full.ready", 64'(mc_ready), 64'd0);
      check("t3.stall", 64'(stall_pipe), 64'd0);
      check_rf("t3.pipe", 1'b1, 5'd3, 32'h33);
      tick();
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    settle();
    check("t3.idle0.ready", 64'(mc_ready), 64'd0);
    check_rf("t3.idle0", 1'b1, 5'd10, 32'hA0);
    tick();
    settle();
    check("t3.accept.ready", 64'(mc_ready), 64'd1);
    check_rf("t3.idle1", 1'b1, 5'd11, 32'hB1);
    tick();
`endif
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mc(1'b0, 5'd0, 32'd0);
`ifdef RF_ARB_STARVE_EN
    settle();
    check_rf("t3.drain11", 1'b1, 5'd11, 32'hB1);
    tick();
`endif
    settle();
    check_rf("t3.drain12", 1'b1, 5'd12, 32'hC2);
    tick();
    settle();
    check("t3.empty.rf_we", 64'(rf_we), 64'd0);
    idle_all();
    tick();

    // T4: pipeline write to $0 is idle; mc result to $0 is consumed, never written.
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_mc(1'b1, 5'd9, 32'h99);
    tick();
    drive_wb(1'b1, 5'd0, 32'hDEAD);
    drive_mc(1'b1, 5'd0, 32'h55);
    rd_a = 5'd9; rd_b = 5'd0;
    settle();
    check_rf("t4.r0_slot", 1'b1, 5'd9, 32'h99);
    check("t4.ready", 64'(mc_ready), 64'd1);
    check("t4.pend_a", 64'(pend_a), 64'd1);
    check("t4.pend_b", 64'(pend_b), 64'd0);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mc(1'b0, 5'd0, 32'd0);
    settle();
    check("t4.r0_dropped", 64'(rf_we), 64'd0);
    check("t4.pend_a_clr", 64'(pend_a), 64'd0);
    tick();
    settle();
    check("t4.still_idle", 64'(rf_we), 64'd0);
    idle_all();
    tick();

    // T5: asynchronous reset mid-drain with two entries buffered.
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_mc(1'b1, 5'd20, 32'h2020);
    tick();
    drive_mc(1'b1, 5'd21, 32'h2121);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mc(1'b0, 5'd0, 32'd0);
    rd_a = 5'd21;
    settle();
    check_rf("t5.drain", 1'b1, 5'd20, 32'h2020);
    check("t5.pend_a", 64'(pend_a), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5.rst.rf_we", 64'(rf_we), 64'd0);
    check("t5.rst.ready", 64'(mc_ready), 64'd1);
    check("t5.rst.pend_a", 64'(pend_a), 64'd0);
    check("t5.rst.stall", 64'(stall_pipe), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t5.post.rf_we", 64'(rf_we), 64'd0);
      check("t5.post.ready", 64'(mc_ready), 64'd1);
      check("t5.post.stall", 64'(stall_pipe), 64'd0);
      check("t5.post.pend_a", 64'(pend_a), 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
